soc_miner_dma_rd: RTL

Read-DMA controller for the SoC miner memory master port. A one-cycle `Go` from the register block starts a transfer of `Length` bytes from the DRAM address in `Src_addr`. The block splits the transfer into AXI INCR read bursts and streams the returned data out on a valid/ready interface to the hashing datapath. It drives the `m_memory_ar*`/`r*` channels; the write channels stay tied off at the top level.

---
 rtl/soc_miner_pkg.sv | 21 ++
 rtl/soc_miner_burst_calc.sv | 40 ++++
 rtl/soc_miner_dma_rd.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/soc_miner_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | soc_miner_pkg : shared types and AXI constants for the SoC miner blocks  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package soc_miner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } dma_rd_state_e;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam int         MAX_BURST_BEATS = 16;
    localparam int         PAGE_BYTES      = 4096;

endpackage
`default_nettype wire

// File: rtl/soc_miner_burst_calc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | soc_miner_burst_calc : beats of the next read burst, capped by the max   |
// | burst size, the remaining beats and the next 4 KB page boundary.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module soc_miner_burst_calc
    import soc_miner_pkg::*;
#(
    parameter int LEN_WIDTH  = 4,
    parameter int BEAT_BYTES = 8,
    parameter int REM_WIDTH  = 29,
    parameter int PAGE_BITS  = $clog2(PAGE_BYTES)
) (
    input  logic [PAGE_BITS-1:0] page_offset,
    input  logic [REM_WIDTH-1:0] remaining,
    output logic [LEN_WIDTH:0]   beats,
    output logic [LEN_WIDTH-1:0] arlen
);

    localparam int                   BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam logic [REM_WIDTH-1:0] MAX_BEATS  = REM_WIDTH'(2 ** LEN_WIDTH);

    logic [PAGE_BITS:0]   page_left;
    logic [REM_WIDTH-1:0] page_beats;
    logic [REM_WIDTH-1:0] lim;

    always_comb begin
        // One extra bit so a page-aligned address yields a full 4096 bytes
        page_left  = (PAGE_BITS+1)'(PAGE_BYTES) - {1'b0, page_offset};
        page_beats = REM_WIDTH'(page_left >> BEAT_SHIFT);
        lim        = MAX_BEATS;
        if (page_beats < lim) lim = page_beats;
        if (remaining < lim)  lim = remaining;
        beats = lim[LEN_WIDTH:0];
        arlen = LEN_WIDTH'(lim - REM_WIDTH'(1));
    end

endmodule
`default_nettype wire

// File: rtl/soc_miner_dma_rd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | soc_miner_dma_rd : read DMA, splits a transfer into AXI INCR bursts and  |
// | streams returned beats to the hashing datapath without buffering.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module soc_miner_dma_rd
    import soc_miner_pkg::*;
#(
    parameter int                  DATA_WIDTH = 64,
    parameter int                  ADDR_WIDTH = 32,
    parameter int                  LEN_WIDTH  = $clog2(MAX_BURST_BEATS),
    parameter int                  ID_WIDTH   = 6,
    parameter logic [ID_WIDTH-1:0] RD_ID      = '0
) (
    input  logic                  Clk,
    input  logic                  RESET,
    input  logic                  Go,
    input  logic [ADDR_WIDTH-3:0] Src_addr,
    input  logic [31:0]           Length,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error,
    output logic                  m_memory_arvalid,
    input  logic                  m_memory_arready,
    output logic [ADDR_WIDTH-1:0] m_memory_araddr,
    output logic [LEN_WIDTH-1:0]  m_memory_arlen,
    output logic [ID_WIDTH-1:0]   m_memory_arid,
    output logic [2:0]            m_memory_arsize,
    output logic [1:0]            m_memory_arburst,
    output logic                  m_memory_arlock,
    output logic [3:0]            m_memory_arcache,
    output logic [2:0]            m_memory_arprot,
    output logic [3:0]            m_memory_arqos,
    input  logic                  m_memory_rvalid,
    output logic                  m_memory_rready,
    input  logic [DATA_WIDTH-1:0] m_memory_rdata,
    input  logic                  m_memory_rlast,
    input  logic [1:0]            m_memory_rresp,
    input  logic [ID_WIDTH-1:0]   m_memory_rid,
    output logic                  Out_valid,
    input  logic                  Out_ready,
    output logic [DATA_WIDTH-1:0] Out_data,
    output logic                  Out_last
);

    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int REM_WIDTH  = 32 - BEAT_SHIFT;
    localparam int PAGE_BITS  = $clog2(PAGE_BYTES);

    dma_rd_state_e          state;
    dma_rd_state_e          state_next;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [REM_WIDTH-1:0]   remaining;
    logic [LEN_WIDTH:0]     burst_left;
    logic                   error_q;
    logic [LEN_WIDTH:0]     calc_beats;
    logic [LEN_WIDTH-1:0]   calc_arlen;
    logic                   zero_len;
    logic                   bad_req;
    logic                   beat_fire;
    logic                   beat_err;

    soc_miner_burst_calc #(
        .LEN_WIDTH  (LEN_WIDTH),
        .BEAT_BYTES (BEAT_BYTES),
        .REM_WIDTH  (REM_WIDTH),
        .PAGE_BITS  (PAGE_BITS)
    ) u_burst_calc (
        .page_offset (addr[PAGE_BITS-1:0]),
        .remaining   (remaining),
        .beats       (calc_beats),
        .arlen       (calc_arlen)
    );

    assign zero_len  = (Length == 32'd0);
    assign bad_req   = !zero_len && (Src_addr[0] || (Length[BEAT_SHIFT-1:0] != '0));
    assign beat_fire = (state == ST_DATA) && m_memory_rvalid && Out_ready;
    assign beat_err  = (m_memory_rresp != AXI_RESP_OKAY) || (m_memory_rid != RD_ID) ||
                       (m_memory_rlast != (burst_left == (LEN_WIDTH+1)'(1)));

    always_ff @(posedge Clk) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next       = state;
        Busy             = (state != ST_IDLE);
        Done             = (state == ST_DONE);
        Error            = error_q;
        m_memory_arvalid = (state == ST_ADDR);
        m_memory_araddr  = addr;
        m_memory_arlen   = (state == ST_ADDR) ? calc_arlen : '0;
        m_memory_rready  = (state == ST_DATA) && Out_ready;
        Out_valid        = (state == ST_DATA) && m_memory_rvalid;
        Out_data         = (state == ST_DATA) ? m_memory_rdata : '0;
        Out_last         = Out_valid && (remaining == REM_WIDTH'(1));
        case (state)
            ST_IDLE: if (Go) state_next = (zero_len || bad_req) ? ST_DONE : ST_ADDR;
            ST_ADDR: if (m_memory_arready) state_next = ST_DATA;
            // Burst end follows the slave's rlast; a mismatch is flagged, not trusted for length
            ST_DATA: if (beat_fire && m_memory_rlast)
                         state_next = (remaining == REM_WIDTH'(1)) ? ST_DONE : ST_ADDR;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (RESET) begin
            addr       <= '0;
            remaining  <= '0;
            burst_left <= '0;
            error_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (Go) begin
                    addr      <= {Src_addr, 2'b00};
                    remaining <= Length[31:BEAT_SHIFT];
                    error_q   <= bad_req;
                end
                ST_ADDR: if (m_memory_arready) burst_left <= calc_beats;
                ST_DATA: if (beat_fire) begin
                    remaining  <= remaining - REM_WIDTH'(1);
                    addr       <= addr + ADDR_WIDTH'(BEAT_BYTES);
                    burst_left <= burst_left - (LEN_WIDTH+1)'(1);
                    if (beat_err) error_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign m_memory_arid    = RD_ID;
    assign m_memory_arsize  = 3'(BEAT_SHIFT);
    assign m_memory_arburst = AXI_BURST_INCR;
    assign m_memory_arlock  = 1'b0;
    assign m_memory_arcache = 4'd0;
    assign m_memory_arprot  = 3'd0;
    assign m_memory_arqos   = 4'd0;

endmodule
`default_nettype wire
